// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller: op encoding, FSM states,
// data width and small op-classification helpers.
package lsu_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LW  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd3;
  localparam logic [2:0] OP_LHU = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } stateT;

  function automatic logic isLoad(input logic [2:0] op);
    return (op <= OP_LHU);
  endfunction

  // Half accesses need an even byte address, word accesses a multiple of four.
  function automatic logic isMisaligned(input logic [2:0] op, input logic [1:0] off);
    logic isHalf;
    logic isWord;
    isHalf = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    isWord = (op == OP_LW) || (op == OP_SW);
    return (isHalf && off[0]) || (isWord && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane datapath: extracts/extends sub-word loads and merges sub-word
// store data into a read word. Misaligned offsets are forced aligned here.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [1:0]        offset,
  input  logic [DATA_W-1:0] readWord,
  input  logic [DATA_W-1:0] storeData,
  output logic [DATA_W-1:0] loadResult,
  output logic [DATA_W-1:0] mergedWord
);

  logic [1:0]  effOff;
  logic [7:0]  laneByte;
  logic [15:0] laneHalf;
  logic [3:0]  byteWe;

  always_comb begin
    case (op)
      OP_LH, OP_LHU, OP_SH: effOff = {offset[1], 1'b0};
      OP_LW, OP_SW:         effOff = 2'b00;
      default:              effOff = offset;
    endcase
  end

  assign laneByte = readWord[{effOff, 3'b000} +: 8];
  assign laneHalf = effOff[1] ? readWord[31:16] : readWord[15:0];

  always_comb begin
    case (op)
      OP_LB:   loadResult = {{24{laneByte[7]}}, laneByte};
      OP_LH:   loadResult = {{16{laneHalf[15]}}, laneHalf};
      OP_LW:   loadResult = readWord;
      OP_LBU:  loadResult = {24'h0, laneByte};
      OP_LHU:  loadResult = {16'h0, laneHalf};
      default: loadResult = '0;
    endcase
  end

  always_comb begin
    case (op)
      OP_SB:   byteWe = 4'b0001 << effOff;
      OP_SH:   byteWe = effOff[1] ? 4'b1100 : 4'b0011;
      OP_SW:   byteWe = 4'b1111;
      default: byteWe = 4'b0000;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gLane
      logic [7:0] srcByte;
      // SB replicates the low byte, SH replicates the low half across lanes.
      always_comb begin
        case (op)
          OP_SB:   srcByte = storeData[7:0];
          OP_SH:   srcByte = storeData[8*(gi%2) +: 8];
          default: srcByte = storeData[8*gi +: 8];
        endcase
      end
      assign mergedWord[8*gi +: 8] = byteWe[gi] ? srcByte : readWord[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/lsu_dm_ctrl.sv
// Load/store controller in front of the data memory word port.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses with resp_err.
module lsu_dm_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_op,
  input  logic [ADDR_W+1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                MemRead,
  output logic                MemWrite,
  output logic [ADDR_W-1:0]   Address,
  output logic [DATA_W-1:0]   WriteData,
  input  logic [DATA_W-1:0]   ReadData
);

  stateT stateReg, stateNext;

  logic [2:0]        opReg;
  logic [1:0]        offReg;
  logic [DATA_W-1:0] wdataReg;

  logic              accept;
  logic              misalign;
  logic [DATA_W-1:0] laneLoad;
  logic [DATA_W-1:0] laneMerged;

  logic [DATA_W-1:0] respRdataNext;
  logic              respErrNext;
  logic [ADDR_W-1:0] addressNext;
  logic [DATA_W-1:0] writeDataNext;

  assign accept = (stateReg == IDLE) && req_valid;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = isMisaligned(req_op, req_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  lsu_lane uLane (
    .op        (opReg),
    .offset    (offReg),
    .readWord  (ReadData),
    .storeData (wdataReg),
    .loadResult(laneLoad),
    .mergedWord(laneMerged)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE: begin
        if (accept) begin
          if (misalign)              stateNext = RESP;
          else if (req_op == OP_SW)  stateNext = WRITE;
          else                       stateNext = READ;
        end
      end
      READ:    stateNext = isLoad(opReg) ? RESP : WRITE;
      WRITE:   stateNext = RESP;
      RESP:    if (resp_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Next values for the data-carrying outputs; enables derive from stateNext.
  always_comb begin
    respRdataNext = resp_rdata;
    respErrNext   = resp_err;
    addressNext   = Address;
    writeDataNext = WriteData;
    if (accept) begin
      addressNext   = req_addr[ADDR_W+1:2];
      respErrNext   = misalign;
      respRdataNext = '0;
      if (req_op == OP_SW) writeDataNext = req_wdata;
    end
    if (stateReg == READ) begin
      if (isLoad(opReg)) respRdataNext = laneLoad;
      else               writeDataNext = laneMerged;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      Address    <= '0;
      WriteData  <= '0;
      opReg      <= OP_LB;
      offReg     <= 2'b00;
      wdataReg   <= '0;
    end else begin
      req_ready  <= (stateNext == IDLE);
      resp_valid <= (stateNext == RESP);
      MemRead    <= (stateNext == READ);
      MemWrite   <= (stateNext == WRITE);
      resp_rdata <= respRdataNext;
      resp_err   <= respErrNext;
      Address    <= addressNext;
      WriteData  <= writeDataNext;
      if (accept) begin
        opReg    <= req_op;
        offReg   <= req_addr[1:0];
        wdataReg <= req_wdata;
      end
    end
  end

endmodule

// File: tb/tb_lsu_dm_ctrl.sv
// Self-checking bench for lsu_dm_ctrl with a behavioural data memory and a
// word-array reference model computed with plain shift/mask arithmetic.
module tb_lsu_dm_ctrl;

  localparam int AW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_op = 3'd0;
  logic [AW+1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          MemRead;
  logic          MemWrite;
  logic [AW-1:0] Address;
  logic [31:0]   WriteData;
  logic [31:0]   ReadData;

  always #5 clock = ~clock;

  lsu_dm_ctrl #(.ADDR_W(AW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address),
    .WriteData(WriteData), .ReadData(ReadData)
  );

  // Data memory: combinational read, write on rising edge, bench preload port.
  logic [31:0] dm     [0:255];
  logic [31:0] refMem [0:255];
  logic        ploadEn = 1'b0;
  logic [7:0]  ploadAddr = '0;
  logic [31:0] ploadData = '0;

  always @(posedge clock) begin
    if (MemWrite)     dm[Address]   <= WriteData;
    else if (ploadEn) dm[ploadAddr] <= ploadData;
  end

  assign ReadData = MemRead ? dm[Address] : 32'h0;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit isMis(input logic [2:0] op, input logic [9:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((op == 3'd1 || op == 3'd4 || op == 3'd6) && (a % 2 != 0)) return 1'b1;
    if ((op == 3'd2 || op == 3'd7) && (a % 4 != 0)) return 1'b1;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] refLoad(input logic [2:0] op, input logic [31:0] w,
                                          input logic [9:0] a);
    longint v;
    int bOff, hOff;
    bOff = 8 * (a % 4);
    hOff = 16 * ((a / 2) % 2);
    case (op)
      3'd0: begin v = (longint'(w) >> bOff) % 256;   if (v > 127)   v = v - 256;   end
      3'd1: begin v = (longint'(w) >> hOff) % 65536; if (v > 32767) v = v - 65536; end
      3'd2: v = longint'(w);
      3'd3: v = (longint'(w) >> bOff) % 256;
      default: v = (longint'(w) >> hOff) % 65536;
    endcase
    return v[31:0];
  endfunction

  function automatic logic [31:0] refStore(input logic [2:0] op, input logic [31:0] w,
                                           input logic [31:0] wd, input logic [9:0] a);
    int sh;
    logic [31:0] m;
    if (op == 3'd5) begin
      sh = 8 * (a % 4);
      m  = 32'hFF << sh;
      return (w & ~m) | ((wd & 32'hFF) << sh);
    end else if (op == 3'd6) begin
      sh = 16 * ((a / 2) % 2);
      m  = 32'hFFFF << sh;
      return (w & ~m) | ((wd & 32'hFFFF) << sh);
    end
    return wd;
  endfunction

  // One complete request/response transaction; entered and left at a negedge.
  task automatic txn(input string name, input logic [2:0] op, input logic [9:0] a,
                     input logic [31:0] wd, input int hold);
    logic [7:0]  wi;
    logic [31:0] expR, expW;
    int expLat, expRd, expWr, cycles, rd, wr;
    bit mis;
    wi   = a[9:2];
    mis  = isMis(op, a);
    expR = 32'h0;
    expW = 32'h0;
    if (mis) begin
      expLat = 1; expRd = 0; expWr = 0;
    end else if (op <= 3'd4) begin
      expR = refLoad(op, refMem[wi], a);
      expLat = 2; expRd = 1; expWr = 0;
    end else begin
      expW = refStore(op, refMem[wi], wd, a);
      expRd = (op == 3'd7) ? 0 : 1;
      expWr = 1;
      expLat = (op == 3'd7) ? 2 : 3;
      refMem[wi] = expW;
    end

    chk({name, " req_ready idle"}, req_ready, 1);
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
    @(posedge clock); #1;
    req_valid = 1'b0; req_op = 3'($urandom); req_addr = 10'($urandom); req_wdata = $urandom;

    cycles = 0; rd = 0; wr = 0;
    while (1) begin
      @(negedge clock);
      cycles++;
      if (resp_valid || cycles > 10) break;
      chk({name, " rd&wr exclusive"}, MemRead & MemWrite, 0);
      if (MemRead) begin
        rd++;
        chk({name, " read address"}, Address, wi);
      end
      if (MemWrite) begin
        wr++;
        chk({name, " write address"}, Address, wi);
        chk({name, " write data"}, WriteData, expW);
      end
      resp_ready = 1'($urandom);
    end
    chk({name, " latency"}, cycles, expLat);
    chk({name, " MemRead cycles"}, rd, expRd);
    chk({name, " MemWrite cycles"}, wr, expWr);
    chk({name, " resp_rdata"}, resp_rdata, expR);
    chk({name, " resp_err"}, resp_err, mis);
    chk({name, " enables idle in RESP"}, {MemRead, MemWrite}, 0);

    for (int h = 0; h < hold; h++) begin
      resp_ready = 1'b0;
      @(negedge clock);
      chk({name, " hold resp_valid"}, resp_valid, 1);
      chk({name, " hold resp_rdata"}, resp_rdata, expR);
      chk({name, " hold req_ready"}, req_ready, 0);
    end
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    chk({name, " resp_valid after handshake"}, resp_valid, 0);
    $display("[TB] %s op=%0d addr=%0d wdata=%h rdata=%h err=%0d lat=%0d", name, op, a, wd,
             expR, mis, cycles);
  endtask

  task automatic chkResetOutputs(input string name);
    chk({name, " req_ready"}, req_ready, 1);
    chk({name, " resp_valid"}, resp_valid, 0);
    chk({name, " resp_rdata"}, resp_rdata, 0);
    chk({name, " resp_err"}, resp_err, 0);
    chk({name, " MemRead"}, MemRead, 0);
    chk({name, " MemWrite"}, MemWrite, 0);
    chk({name, " Address"}, Address, 0);
    chk({name, " WriteData"}, WriteData, 0);
  endtask

  initial begin
    logic [31:0] d;
    logic [9:0]  ra;
    // Preload memory while held in reset.
    for (int i = 0; i < 256; i++) begin
      d = (i == 20) ? 32'h55555555 : (i == 40) ? 32'hAAAAAAAA : $urandom;
      refMem[i] = d;
      ploadAddr = 8'(i); ploadData = d; ploadEn = 1'b1;
      @(posedge clock); #1;
    end
    ploadEn = 1'b0;
    @(negedge clock);
    chkResetOutputs("reset");
    reset = 1'b0;
    @(negedge clock);

    txn("LW80",       3'd2, 10'd80,  32'h0, 0);
    txn("LB161",      3'd0, 10'd161, 32'h0, 0);
    txn("LBU161",     3'd3, 10'd161, 32'h0, 1);
    txn("LHU162",     3'd4, 10'd162, 32'h0, 0);
    txn("SB81",       3'd5, 10'd81,  32'h000000CC, 0);
    txn("LW80 after SB", 3'd2, 10'd80, 32'h0, 0);
    txn("SW160 hold5", 3'd7, 10'd160, 32'hCCCCCCCC, 5);
    txn("LH83",       3'd1, 10'd83,  32'h0, 0);
    txn("LW163",      3'd2, 10'd163, 32'h0, 0);
    txn("SH83",       3'd6, 10'd83,  32'h1234BEEF, 0);

    // Reset during READ of a sub-word store: the write must never issue.
    chk("rst req_ready idle", req_ready, 1);
    req_valid = 1'b1; req_op = 3'd6; req_addr = 10'd82; req_wdata = 32'hDEADBEEF;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(negedge clock);
    chk("rst in READ MemRead", MemRead, 1);
    reset = 1'b1;
    #1;
    chkResetOutputs("midop reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("midop reset MemWrite", MemWrite, 0);
    end
    reset = 1'b0;
    @(negedge clock);
    chk("word20 unchanged dm", dm[20], refMem[20]);
    $display("[TB] reset during SH addr=82 read phase");
    txn("LW80 after reset", 3'd2, 10'd80, 32'h0, 0);

    // Top word index.
    txn("SB1023",  3'd5, 10'd1023, 32'h000000A5, 0);
    txn("LW1020",  3'd2, 10'd1020, 32'h0, 0);
    txn("LB1023",  3'd0, 10'd1023, 32'h0, 0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 0) ra = 10'($urandom_range(64, 95));
      else                           ra = 10'($urandom);
      txn($sformatf("rand%0d", n), 3'($urandom), ra, $urandom, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
